// File: rtl/router_psum_load_pkg.sv
// Shared definitions for the psum routers: default geometry, FSM state
// encoding and the helper that locates one psum element inside a packed vector.
package router_psum_load_pkg;

  localparam int PSUM_DATA_BITWIDTH     = 16;
  localparam int PSUM_ADDR_BITWIDTH_GLB = 10;
  localparam int PSUM_X_DIM             = 5;
  localparam int PSUM_NUM_ITER          = 3;
  localparam int PSUM_READ_ADDR_DEF     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    LOAD  = 2'b11
  } psum_state_e;

  // Element idx of a packed psum vector starts at bit idx*width.
  function automatic int psum_slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/router_psum_load_deserializer.sv
// Index-addressed register bank: each valid strobe writes the incoming psum
// into the next element slot. The slot counter restarts on clear.
module psum_deserializer
  import router_psum_load_pkg::*;
#(
  parameter int DATA_BITWIDTH = PSUM_DATA_BITWIDTH,
  parameter int NUM_ELEM      = PSUM_X_DIM
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              valid,
  input  logic [DATA_BITWIDTH-1:0]          data,
  output logic [DATA_BITWIDTH*NUM_ELEM-1:0] vec
);

  localparam int CNT_W = $clog2(NUM_ELEM + 1);
  localparam logic [CNT_W-1:0] ELEM_CNT = CNT_W'(NUM_ELEM);

  logic [CNT_W-1:0] wr_cnt_r;

  // Slot counter and element storage; extra strobes beyond NUM_ELEM are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_r <= CNT_W'(0);
      vec      <= (DATA_BITWIDTH*NUM_ELEM)'(0);
    end else if (clear) begin
      wr_cnt_r <= CNT_W'(0);
    end else if (valid && (wr_cnt_r < ELEM_CNT)) begin
      vec[psum_slice_lsb(int'(wr_cnt_r), DATA_BITWIDTH) +: DATA_BITWIDTH] <= data;
      wr_cnt_r <= wr_cnt_r + CNT_W'(1);
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

endmodule

// File: rtl/router_psum_load.sv
// Psum load router: reads X_dim psums serially from the psum GLB, packs them
// into one vector and pulses the PE-row spad load. The read base advances by
// X_dim per run and wraps after NUM_ITER runs.
module router_psum_load
  import router_psum_load_pkg::*;
#(
  parameter int DATA_BITWIDTH     = PSUM_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = PSUM_ADDR_BITWIDTH_GLB,
  parameter int X_dim             = PSUM_X_DIM,
  parameter int NUM_ITER          = PSUM_NUM_ITER,
  parameter int PSUM_READ_ADDR    = PSUM_READ_ADDR_DEF
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_psum_ctrl,
  input  logic [DATA_BITWIDTH-1:0]       r_data_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0]   r_addr_glb_psum,
  output logic                           read_en_glb_psum,
  output logic [DATA_BITWIDTH*X_dim-1:0] w_data_spad_psum,
  output logic                           load_en_spad,
  output logic                           busy
);

  localparam int CNT_W  = $clog2(X_dim + 1);
  localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic [CNT_W-1:0]             RD_LAST     = CNT_W'(X_dim - 1);
  localparam logic [ITER_W-1:0]            ITER_LAST   = ITER_W'(NUM_ITER - 1);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] ADDR_BASE   = ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] ADDR_STRIDE = ADDR_BITWIDTH_GLB'(X_dim);

  psum_state_e                  state_r;
  psum_state_e                  state_s;
  logic                         start_s;
  logic [CNT_W-1:0]             rd_cnt_r;
  logic [ITER_W-1:0]            iter_r;
  // Running read base, kept as PSUM_READ_ADDR + iter*X_dim without a multiplier.
  logic [ADDR_BITWIDTH_GLB-1:0] iter_base_r;
  // GLB data is valid the cycle after a read strobe.
  logic                         capture_r;

  // Next-state logic; a start request is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_psum_ctrl) begin
          state_s = ISSUE;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (rd_cnt_r == RD_LAST) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN:   state_s = LOAD;
      LOAD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered strobes, read address generation and iteration bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_r         <= CNT_W'(0);
      iter_r           <= ITER_W'(0);
      iter_base_r      <= ADDR_BASE;
      r_addr_glb_psum  <= ADDR_BASE;
      read_en_glb_psum <= 1'b0;
      load_en_spad     <= 1'b0;
      busy             <= 1'b0;
      capture_r        <= 1'b0;
    end else begin
      read_en_glb_psum <= (state_r == ISSUE);
      load_en_spad     <= (state_r == LOAD);
      busy             <= (state_r != IDLE);
      capture_r        <= read_en_glb_psum;

      if (start_s) begin
        rd_cnt_r <= CNT_W'(0);
      end else if (state_r == ISSUE) begin
        r_addr_glb_psum <= iter_base_r + ADDR_BITWIDTH_GLB'(rd_cnt_r);
        rd_cnt_r        <= rd_cnt_r + CNT_W'(1);
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end

      if (state_r == LOAD) begin
        if (iter_r == ITER_LAST) begin
          iter_r      <= ITER_W'(0);
          iter_base_r <= ADDR_BASE;
        end else begin
          iter_r      <= iter_r + ITER_W'(1);
          iter_base_r <= iter_base_r + ADDR_STRIDE;
        end
      end else begin
        iter_r      <= iter_r;
        iter_base_r <= iter_base_r;
      end
    end
  end

  psum_deserializer #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .NUM_ELEM      (X_dim)
  ) u_deser (
    .clk   (clk),
    .reset (reset),
    .clear (start_s),
    .valid (capture_r),
    .data  (r_data_glb_psum),
    .vec   (w_data_spad_psum)
  );

endmodule

// File: tb/tb_router_psum_load.sv
// Bench for router_psum_load: GLB memory model, timing-rule reference model
// checked every cycle, plus directed runs with literal expectations.
module tb_router_psum_load;
  import router_psum_load_pkg::*;

  localparam int DW    = PSUM_DATA_BITWIDTH;
  localparam int AW    = PSUM_ADDR_BITWIDTH_GLB;
  localparam int XD    = PSUM_X_DIM;
  localparam int NI    = PSUM_NUM_ITER;
  localparam int BASE0 = PSUM_READ_ADDR_DEF;
  localparam int VW    = DW * XD;

  logic          clk;
  logic          reset;
  logic          load_psum_ctrl;
  logic [DW-1:0] r_data_glb_psum;
  logic [AW-1:0] r_addr_glb_psum;
  logic          read_en_glb_psum;
  logic [VW-1:0] w_data_spad_psum;
  logic          load_en_spad;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] pend;

  // reference model state
  int          edge_cnt = 0;
  bit          in_run   = 1'b0;
  int          s_edge   = 0;
  int          iter_m   = 0;
  logic [AW-1:0] base_m = '0;
  logic [VW-1:0] exp_vec = '0;

  router_psum_load dut (
    .clk              (clk),
    .reset            (reset),
    .load_psum_ctrl   (load_psum_ctrl),
    .r_data_glb_psum  (r_data_glb_psum),
    .r_addr_glb_psum  (r_addr_glb_psum),
    .read_en_glb_psum (read_en_glb_psum),
    .w_data_spad_psum (w_data_spad_psum),
    .load_en_spad     (load_en_spad),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // GLB read port: data for a strobe seen in one cycle appears in the next.
  initial begin
    pend = '0;
    r_data_glb_psum = '0;
    forever begin
      @(negedge clk);
      r_data_glb_psum = pend;
      pend = read_en_glb_psum ? mem[r_addr_glb_psum] : DW'($urandom);
    end
  end

  // Reference model (run timeline relative to the accepting edge) and per-cycle compare.
  initial begin
    int t;
    bit e_rd, e_ld, e_busy;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        in_run  = 1'b0;
        iter_m  = 0;
        exp_vec = '0;
      end else begin
        if (in_run && (edge_cnt - s_edge == XD + 2)) begin
          for (int k = 0; k < XD; k++)
            exp_vec[k*DW +: DW] = mem[(int'(base_m) + k) % (1 << AW)];
          iter_m = (iter_m + 1) % NI;
        end
        if (load_psum_ctrl && (!in_run || (edge_cnt - s_edge >= XD + 3))) begin
          in_run = 1'b1;
          s_edge = edge_cnt;
          base_m = AW'((BASE0 + iter_m * XD) % (1 << AW));
        end
      end
      #1;
      t = edge_cnt - s_edge;
      if (reset) begin
        check("rst_read_en", read_en_glb_psum, 1'b0);
        check("rst_load_en", load_en_spad, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", r_addr_glb_psum, AW'(BASE0));
        check("rst_vec", w_data_spad_psum, '0);
      end else begin
        e_rd   = in_run && (t >= 1) && (t <= XD);
        e_ld   = in_run && (t == XD + 2);
        e_busy = in_run && (t >= 1) && (t <= XD + 2);
        check("m_read_en", read_en_glb_psum, e_rd);
        check("m_load_en", load_en_spad, e_ld);
        check("m_busy", busy, e_busy);
        if (e_rd)
          check("m_addr", r_addr_glb_psum, base_m + AW'(t - 1));
        if (!in_run || (t <= 2) || (t >= XD + 2))
          check("m_vec", w_data_spad_psum, exp_vec);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    load_psum_ctrl = 1'b1;
    @(negedge clk);
    load_psum_ctrl = 1'b0;
  endtask

  // One run from idle; returns at cycle 7 (+1 time unit) of the run.
  task automatic run_check(input logic [AW-1:0] exp_base, input logic [VW-1:0] vec, input bit chk_vec);
    pulse_start();
    for (int k = 1; k <= XD + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("run_base", r_addr_glb_psum, exp_base);
      if (k == XD + 2) begin
        check("run_load_pulse", load_en_spad, 1'b1);
        if (chk_vec) check("run_vec", w_data_spad_psum, vec);
      end
    end
  endtask

  initial begin
    int loads, reads, last_ld;
    logic [VW-1:0] v;
    reset = 1'b1;
    load_psum_ctrl = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // basic load
    for (int i = 0; i < XD; i++) mem[i] = DW'(10 * (i + 1));
    pulse_start();
    for (int k = 1; k <= XD + 2; k++) begin
      @(posedge clk); #1;
      if (k <= XD) begin
        check("basic_rd_en", read_en_glb_psum, 1'b1);
        check("basic_addr", r_addr_glb_psum, AW'(k - 1));
      end
      if (k == XD + 2) begin
        check("basic_load", load_en_spad, 1'b1);
        check("basic_vec", w_data_spad_psum, {16'd50, 16'd40, 16'd30, 16'd20, 16'd10});
      end
    end

    // iteration and wrap, back to back
    for (int i = XD; i < 3 * XD; i++) mem[i] = DW'($urandom);
    v = '0;
    run_check(AW'(5), v, 1'b0);
    run_check(AW'(10), v, 1'b0);
    run_check(AW'(0), {16'd50, 16'd40, 16'd30, 16'd20, 16'd10}, 1'b1);

    // start while busy (iter now 1, base 5)
    loads = 0; reads = 0;
    pulse_start();
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) load_psum_ctrl = 1'b1;
      if (k == 3) load_psum_ctrl = 1'b0;
      reads += int'(read_en_glb_psum);
      loads += int'(load_en_spad);
      if (k <= XD + 2) check("busy_high", busy, 1'b1);
    end
    check("busy_start_loads", loads, 1);
    check("busy_start_reads", reads, XD);

    // reset mid-operation
    pulse_start();
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_read_en", read_en_glb_psum, 1'b0);
    check("async_load_en", load_en_spad, 1'b0);
    check("async_busy", busy, 1'b0);
    loads = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; loads += int'(load_en_spad); end
    check("reset_no_load", loads, 0);
    run_check(AW'(0), v, 1'b0);

    // extreme data into iteration 1 (base 5), raw bits only
    mem[5] = 16'h8000; mem[6] = 16'hFFFF; mem[7] = 16'h0001; mem[8] = 16'h7FFF; mem[9] = 16'h8000;
    run_check(AW'(5), {16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000}, 1'b1);

    // held start: one run every X_dim+3 cycles
    loads = 0; last_ld = -1;
    load_psum_ctrl = 1'b1;
    for (int i = 0; i < 4 * (XD + 3); i++) begin
      @(posedge clk); #1;
      if (load_en_spad) begin
        if (last_ld >= 0) check("held_period", i - last_ld, XD + 3);
        last_ld = i;
        loads++;
      end
    end
    load_psum_ctrl = 1'b0;
    repeat (10) begin @(posedge clk); #1; loads += int'(load_en_spad); end
    check("held_loads", loads, 4);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3 * XD; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      load_psum_ctrl = ($urandom_range(2) == 0);
      reset = ($urandom_range(149) == 0);
    end
    @(negedge clk);
    load_psum_ctrl = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
